// File: rtl/alu_arbiter.sv
// Round-robin arbiter sharing one combinational ALU between two valid/ready requesters.
// Optional macro ALU_OPCODE_CHECK_EN: opcodes above 4'b1010 are blocked and answered with rsp_err=1.
module alu_arbiter #(
  parameter int DATA_W = 32,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [1:0]        req_valid,
  output logic [1:0]        req_ready,
  input  logic [DATA_W-1:0] req0_a,
  input  logic [DATA_W-1:0] req0_b,
  input  logic [3:0]        req0_op,
  input  logic [DATA_W-1:0] req1_a,
  input  logic [DATA_W-1:0] req1_b,
  input  logic [3:0]        req1_op,
  output logic [1:0]        rsp_valid,
  input  logic [1:0]        rsp_ready,
  output logic [DATA_W-1:0] rsp_result,
  output logic              rsp_zero,
  output logic              rsp_carry,
  output logic              rsp_err,
  output logic [DATA_W-1:0] alu_a,
  output logic [DATA_W-1:0] alu_b,
  output logic [3:0]        alu_opcode,
  input  logic [DATA_W-1:0] alu_result,
  input  logic              alu_zero,
  input  logic              alu_carry,
  output logic              busy,
  output logic [CNT_W-1:0]  ops_done
);

  typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

  state_t             r_state;
  state_t             w_nextState;
  logic               r_lastGrant;
  logic               r_grant;
  logic               w_grant;
  logic               w_accept;
  logic               w_rspDone;
  logic [DATA_W-1:0]  w_selA;
  logic [DATA_W-1:0]  w_selB;
  logic [3:0]         w_selOp;
  logic [DATA_W-1:0]  r_aluA;
  logic [DATA_W-1:0]  r_aluB;
  logic [3:0]         r_aluOp;
  logic [DATA_W-1:0]  r_rspResult;
  logic               r_rspZero;
  logic               r_rspCarry;
  logic [CNT_W-1:0]   r_opsDone;

  // A lone requester always wins; contention goes to whoever was not served last.
  always_comb begin
    w_grant = 1'b0;
    case (req_valid)
      2'b10:   w_grant = 1'b1;
      2'b11:   w_grant = ~r_lastGrant;
      default: w_grant = 1'b0;
    endcase
  end

  assign w_accept  = (r_state == IDLE) && (req_valid != 2'b00);
  assign w_rspDone = (r_state == RESP) && rsp_ready[r_grant];
  assign w_selA    = w_grant ? req1_a  : req0_a;
  assign w_selB    = w_grant ? req1_b  : req0_b;
  assign w_selOp   = w_grant ? req1_op : req0_op;

  always_ff @(posedge clk) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_nextState;
  end

  always_comb begin
    w_nextState = r_state;
    req_ready   = 2'b00;
    rsp_valid   = 2'b00;
    case (r_state)
      IDLE: begin
        if (req_valid != 2'b00) begin
          req_ready   = w_grant ? 2'b10 : 2'b01;
          w_nextState = EXEC;
        end
      end
      EXEC: w_nextState = RESP;
      RESP: begin
        rsp_valid = r_grant ? 2'b10 : 2'b01;
        if (rsp_ready[r_grant]) w_nextState = IDLE;
      end
      default: w_nextState = IDLE;
    endcase
  end

`ifdef ALU_OPCODE_CHECK_EN
  localparam logic [3:0] OP_MAX = 4'b1010;
  logic r_illegal;
  logic r_rspErr;
  logic w_illegal;

  assign w_illegal = (w_selOp > OP_MAX);
  assign rsp_err   = r_rspErr;

  // Illegal opcodes never reach the ALU; EXEC substitutes a fixed error response.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_illegal <= 1'b0;
      r_rspErr  <= 1'b0;
    end else begin
      if (w_accept) r_illegal <= w_illegal;
      if (r_state == EXEC) r_rspErr <= r_illegal;
    end
  end
`else
  assign rsp_err = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      r_lastGrant <= 1'b1;
      r_grant     <= 1'b0;
      r_aluA      <= '0;
      r_aluB      <= '0;
      r_aluOp     <= '0;
      r_rspResult <= '0;
      r_rspZero   <= 1'b0;
      r_rspCarry  <= 1'b0;
      r_opsDone   <= '0;
    end else begin
      if (w_accept) begin
        r_grant     <= w_grant;
        r_lastGrant <= w_grant;
`ifdef ALU_OPCODE_CHECK_EN
        if (!w_illegal) begin
`else
        begin
`endif
          r_aluA  <= w_selA;
          r_aluB  <= w_selB;
          r_aluOp <= w_selOp;
        end
      end
      if (r_state == EXEC) begin
`ifdef ALU_OPCODE_CHECK_EN
        if (r_illegal) begin
          r_rspResult <= '0;
          r_rspZero   <= 1'b1;
          r_rspCarry  <= 1'b0;
        end else
`endif
        begin
          r_rspResult <= alu_result;
          r_rspZero   <= alu_zero;
          r_rspCarry  <= alu_carry;
        end
      end
      if (w_rspDone && (r_opsDone != {CNT_W{1'b1}})) r_opsDone <= r_opsDone + 1'b1;
    end
  end

  assign alu_a      = r_aluA;
  assign alu_b      = r_aluB;
  assign alu_opcode = r_aluOp;
  assign rsp_result = r_rspResult;
  assign rsp_zero   = r_rspZero;
  assign rsp_carry  = r_rspCarry;
  assign ops_done   = r_opsDone;
  assign busy       = (r_state != IDLE);

endmodule
